// File: rtl/iq_symbol_sched.sv
// rtl/iq_symbol_sched.sv - IQ symbol FIFO and per-symbol scheduler driving a modulator
module iq_symbol_sched #(
  parameter int SPS         = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int PRIME_LEVEL = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       sym_valid,
  input  logic [7:0] sym_i,
  input  logic [7:0] sym_q,
  output logic       sym_ready,
  output logic [7:0] i,
  output logic [7:0] q,
  output logic       mod_reset_,
  output logic       sym_strobe,
  output logic       underrun,
  output logic [4:0] level,
  output logic       busy
);

  localparam int CW = $clog2(SPS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(SPS - 1);
  localparam logic [4:0]    DEPTH_L  = 5'(FIFO_DEPTH);
  localparam logic [4:0]    PRIME_L  = 5'(PRIME_LEVEL);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, UNDERRUN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          stop_req, stop_nxt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    mem_i [FIFO_DEPTH];
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    i_nxt, q_nxt;
  logic          mod_nxt, strobe_nxt, underrun_nxt;
  logic          push, pop, boundary, stop_pend;

  assign sym_ready = (level < DEPTH_L);
  assign busy      = (state != IDLE);
  assign push      = sym_valid && sym_ready;
  assign boundary  = (cnt == CNT_LAST);
  // A stop requested on the boundary cycle itself is honoured at that boundary.
  assign stop_pend = stop_req || !enable;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    stop_nxt     = stop_req;
    pop          = 1'b0;
    i_nxt        = i;
    q_nxt        = q;
    mod_nxt      = mod_reset_;
    strobe_nxt   = 1'b0;
    underrun_nxt = underrun;
    case (state)
      IDLE: begin
        cnt_nxt  = '0;
        stop_nxt = 1'b0;
        if (enable) begin
          state_nxt    = PRIME;
          underrun_nxt = 1'b0;
        end
      end
      PRIME: begin
        cnt_nxt  = '0;
        stop_nxt = 1'b0;
        if (!enable) begin
          state_nxt = IDLE;
        end else if (level >= PRIME_L) begin
          state_nxt  = RUN;
          pop        = 1'b1;
          i_nxt      = mem_i[rd_ptr];
          q_nxt      = mem_q[rd_ptr];
          mod_nxt    = 1'b1;
          strobe_nxt = 1'b1;
        end
      end
      RUN, UNDERRUN: begin
        cnt_nxt  = boundary ? '0 : cnt + CW'(1);
        stop_nxt = stop_pend;
        if (boundary) begin
          if (stop_pend) begin
            state_nxt = IDLE;
            stop_nxt  = 1'b0;
            i_nxt     = '0;
            q_nxt     = '0;
            mod_nxt   = 1'b0;
          end else if ((state == RUN && level != 5'd0) ||
                       (state == UNDERRUN && level >= PRIME_L)) begin
            state_nxt  = RUN;
            pop        = 1'b1;
            i_nxt      = mem_i[rd_ptr];
            q_nxt      = mem_q[rd_ptr];
            strobe_nxt = 1'b1;
          end else begin
            state_nxt    = UNDERRUN;
            i_nxt        = '0;
            q_nxt        = '0;
            underrun_nxt = 1'b1;
            strobe_nxt   = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      stop_req   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      i          <= '0;
      q          <= '0;
      mod_reset_ <= 1'b0;
      sym_strobe <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      stop_req   <= stop_nxt;
      i          <= i_nxt;
      q          <= q_nxt;
      mod_reset_ <= mod_nxt;
      sym_strobe <= strobe_nxt;
      underrun   <= underrun_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + 5'd1;
        2'b01:   level <= level - 5'd1;
        default: level <= level;
      endcase
    end
  end

  // Storage carries no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_i[wr_ptr] <= sym_i;
      mem_q[wr_ptr] <= sym_q;
    end
  end

endmodule

// File: tb/tb_iq_symbol_sched.sv
// tb/tb_iq_symbol_sched.sv - self-checking bench for iq_symbol_sched
module tb_iq_symbol_sched;

  localparam int SPS = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       sym_valid = 1'b0;
  logic [7:0] sym_i = '0;
  logic [7:0] sym_q = '0;
  logic       sym_ready;
  logic [7:0] i, q;
  logic       mod_reset_, sym_strobe, underrun, busy;
  logic [4:0] level;

  int checks = 0;
  int errors = 0;
  int n;
  bit ok;

  iq_symbol_sched dut (
    .clk(clk), .reset(reset), .enable(enable), .sym_valid(sym_valid),
    .sym_i(sym_i), .sym_q(sym_q), .sym_ready(sym_ready), .i(i), .q(q),
    .mod_reset_(mod_reset_), .sym_strobe(sym_strobe), .underrun(underrun),
    .level(level), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; enable = 1'b0; sym_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic push_sym(input logic [7:0] a, input logic [7:0] b);
    sym_valid = 1'b1; sym_i = a; sym_q = b;
    @(negedge clk);
    sym_valid = 1'b0;
  endtask

  task automatic wait_strobe(input int max_cyc, output int cnt, output bit seen);
    cnt = 0; seen = 0;
    while (!seen && cnt < max_cyc) begin
      @(negedge clk);
      cnt++;
      if (sym_strobe) seen = 1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if ({i, q} !== 16'd0) begin errors++; $display("FAIL reset_iq: got %h required 0000", {i, q}); end
    checks++; if (mod_reset_ !== 1'b0 || sym_strobe !== 1'b0 || underrun !== 1'b0) begin errors++;
      $display("FAIL reset_flags: mod=%b strobe=%b underrun=%b required 0 0 0", mod_reset_, sym_strobe, underrun); end
    checks++; if (level !== 5'd0 || sym_ready !== 1'b1 || busy !== 1'b0) begin errors++;
      $display("FAIL reset_fifo: level=%0d ready=%b busy=%b required 0 1 0", level, sym_ready, busy); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    push_sym(8'd10, 8'd20);
    push_sym(8'd30, 8'd40);
    enable = 1'b1;
    wait_strobe(8, n, ok);
    checks++; if (!ok || n !== 2) begin errors++; $display("FAIL basic_start: seen=%b after %0d required 2", ok, n); end
    checks++; if (i !== 8'd10 || q !== 8'd20 || mod_reset_ !== 1'b1) begin errors++;
      $display("FAIL basic_first: i=%0d q=%0d mod=%b required 10 20 1", i, q, mod_reset_); end
    wait_strobe(40, n, ok);
    checks++; if (!ok || n !== SPS) begin errors++; $display("FAIL basic_period: %0d clocks required %0d", n, SPS); end
    checks++; if (i !== 8'd30 || q !== 8'd40) begin errors++; $display("FAIL basic_second: i=%0d q=%0d required 30 40", i, q); end
  endtask

  task automatic test_fill();
    do_reset();
    sym_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      sym_i = 8'(k + 1); sym_q = 8'(100 + k);
      @(negedge clk);
    end
    sym_valid = 1'b0;
    checks++; if (level !== 5'd4 || sym_ready !== 1'b0) begin errors++;
      $display("FAIL fill_level: level=%0d ready=%b required 4 0", level, sym_ready); end
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_strobe(40, n, ok);
      checks++; if (!ok || i !== 8'(k + 1) || q !== 8'(100 + k)) begin errors++;
        $display("FAIL fill_order%0d: i=%0d q=%0d required %0d %0d", k, i, q, k + 1, 100 + k); end
    end
    wait_strobe(40, n, ok);
    checks++; if (!ok || {i, q} !== 16'd0 || underrun !== 1'b1) begin errors++;
      $display("FAIL fill_fifth: i=%0d q=%0d underrun=%b required 0 0 1", i, q, underrun); end
  endtask

  task automatic test_underrun();
    do_reset();
    push_sym(8'd1, 8'd2);
    push_sym(8'd3, 8'd4);
    enable = 1'b1;
    wait_strobe(8, n, ok);
    wait_strobe(40, n, ok);
    checks++; if (!ok || i !== 8'd3 || underrun !== 1'b0) begin errors++;
      $display("FAIL ur_second: i=%0d underrun=%b required 3 0", i, underrun); end
    wait_strobe(40, n, ok);
    checks++; if (!ok || n !== SPS || {i, q} !== 16'd0 || underrun !== 1'b1 || mod_reset_ !== 1'b1 || busy !== 1'b1) begin errors++;
      $display("FAIL ur_enter: n=%0d iq=%h underrun=%b mod=%b busy=%b required %0d 0000 1 1 1", n, {i, q}, underrun, mod_reset_, busy, SPS); end
    wait_strobe(40, n, ok);
    checks++; if (!ok || n !== SPS || {i, q} !== 16'd0) begin errors++;
      $display("FAIL ur_repeat: n=%0d iq=%h required %0d 0000", n, {i, q}, SPS); end
    push_sym(8'd5, 8'd6);
    push_sym(8'd7, 8'd8);
    wait_strobe(40, n, ok);
    checks++; if (!ok || n !== SPS - 2 || i !== 8'd5 || q !== 8'd6 || underrun !== 1'b1) begin errors++;
      $display("FAIL ur_resume: n=%0d i=%0d q=%0d underrun=%b required %0d 5 6 1", n, i, q, underrun, SPS - 2); end
    wait_strobe(40, n, ok);
    checks++; if (!ok || n !== SPS || i !== 8'd7) begin errors++; $display("FAIL ur_next: n=%0d i=%0d required %0d 7", n, i, SPS); end
  endtask

  task automatic test_stop();
    bit held;
    do_reset();
    push_sym(8'd11, 8'd12);
    push_sym(8'd13, 8'd14);
    push_sym(8'd15, 8'd16);
    enable = 1'b1;
    wait_strobe(8, n, ok);
    repeat (5) @(negedge clk);
    enable = 1'b0;
    held = 1;
    for (int e = 6; e < SPS; e++) begin
      @(negedge clk);
      if (e == 8) enable = 1'b1;
      if (i !== 8'd11 || q !== 8'd12 || mod_reset_ !== 1'b1 || sym_strobe !== 1'b0) held = 0;
    end
    checks++; if (!held) begin errors++; $display("FAIL stop_hold: i=%0d q=%0d mod=%b required 11 12 1", i, q, mod_reset_); end
    @(negedge clk);
    checks++; if ({i, q} !== 16'd0 || mod_reset_ !== 1'b0 || sym_strobe !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL stop_idle: iq=%h mod=%b strobe=%b busy=%b required 0000 0 0 0", {i, q}, mod_reset_, sym_strobe, busy); end
    checks++; if (level !== 5'd2) begin errors++; $display("FAIL stop_level: level=%0d required 2", level); end
    wait_strobe(8, n, ok);
    checks++; if (!ok || n !== 2 || i !== 8'd13 || q !== 8'd14) begin errors++;
      $display("FAIL stop_retain: n=%0d i=%0d q=%0d required 2 13 14", n, i, q); end
  endtask

  task automatic test_push_pop();
    do_reset();
    push_sym(8'd21, 8'd22);
    push_sym(8'd23, 8'd24);
    enable = 1'b1;
    wait_strobe(8, n, ok);
    checks++; if (!ok || level !== 5'd1) begin errors++; $display("FAIL pp_level1: level=%0d required 1", level); end
    repeat (SPS - 1) @(negedge clk);
    sym_valid = 1'b1; sym_i = 8'd25; sym_q = 8'd26;
    @(negedge clk);
    sym_valid = 1'b0;
    checks++; if (sym_strobe !== 1'b1 || i !== 8'd23 || q !== 8'd24 || level !== 5'd1) begin errors++;
      $display("FAIL pp_boundary: strobe=%b i=%0d q=%0d level=%0d required 1 23 24 1", sym_strobe, i, q, level); end
    wait_strobe(40, n, ok);
    checks++; if (!ok || n !== SPS || i !== 8'd25 || q !== 8'd26 || level !== 5'd0) begin errors++;
      $display("FAIL pp_next: n=%0d i=%0d q=%0d level=%0d required %0d 25 26 0", n, i, q, level, SPS); end
  endtask

  task automatic test_async_reset();
    do_reset();
    push_sym(8'd31, 8'd32);
    push_sym(8'd33, 8'd34);
    push_sym(8'd35, 8'd36);
    enable = 1'b1;
    wait_strobe(8, n, ok);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if ({i, q} !== 16'd0 || mod_reset_ !== 1'b0 || level !== 5'd0 || busy !== 1'b0 || sym_ready !== 1'b1) begin errors++;
      $display("FAIL async_reset: iq=%h mod=%b level=%0d busy=%b ready=%b required 0000 0 0 0 1", {i, q}, mod_reset_, level, busy, sym_ready); end
    @(negedge clk);
    enable = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL async_after: busy=%b level=%0d required 0 0", busy, level); end
  endtask

  task automatic test_random();
    logic [15:0] model_q[$];
    logic [15:0] pend_data;
    bit          pend;
    int          last_strobe;
    int          prob;
    do_reset();
    enable = 1'b1;
    pend = 0;
    last_strobe = -1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (sym_strobe) begin
        if (last_strobe >= 0) begin
          checks++; if (cyc - last_strobe !== SPS) begin errors++;
            $display("FAIL rnd_period: %0d clocks at cycle %0d required %0d", cyc - last_strobe, cyc, SPS); end
        end
        last_strobe = cyc;
        if ({i, q} != 16'd0) begin
          checks++;
          if (model_q.size() == 0) begin errors++; $display("FAIL rnd_unexpected: iq=%h at cycle %0d with model empty", {i, q}, cyc); end
          else begin
            if ({i, q} !== model_q[0]) begin errors++;
              $display("FAIL rnd_data: iq=%h required %h at cycle %0d", {i, q}, model_q[0], cyc); end
            void'(model_q.pop_front());
          end
        end else begin
          checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL rnd_zero_flag: underrun=%b required 1 at cycle %0d", underrun, cyc); end
        end
      end
      if (pend) model_q.push_back(pend_data);
      checks++; if (level !== 5'(model_q.size()) || sym_ready !== (model_q.size() < DEPTH)) begin errors++;
        $display("FAIL rnd_level: level=%0d ready=%b required %0d at cycle %0d", level, sym_ready, model_q.size(), cyc); end
      prob = ((cyc / 500) % 2 == 0) ? 8 : 30;
      sym_valid = ($urandom_range(0, prob - 1) == 0);
      sym_i = 8'($urandom_range(1, 255));
      sym_q = 8'($urandom_range(0, 255));
      pend = sym_valid && sym_ready;
      pend_data = {sym_i, sym_q};
    end
    sym_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_underrun();
    test_stop();
    test_push_pop();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
